// File: rtl/fetch_decode_buffer.sv
// Fetch->Decode instruction buffer: in-order FIFO of {pc, inst} pairs with flush on redirect.
// Latency: one cycle from an accepted push into an empty buffer to out_*; no comb in->out path.
// Backpressure: in_ready = !full from registered count only; a pop while full does not admit a push.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_inst/in_pc/in_ready  Fetch side handshake and payload
//   flush                          drop every entry and this cycle's input
//   out_valid/out_inst/out_pc/out_ready  Decode side; NOP_INST / 0 presented when empty
//   count                          occupancy 0..DEPTH
//   stall_cnt                      (FETCH_DECODE_STALL_CNT_EN only) saturating count of
//                                  cycles where Decode held off a valid head
//
// Optional feature macro: FETCH_DECODE_STALL_CNT_EN
module fetch_decode_buffer #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [DATA_W-1:0] NOP_INST = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_inst,
    input  logic [DATA_W-1:0]       in_pc,
    output logic                    in_ready,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_inst,
    output logic [DATA_W-1:0]       out_pc,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count
`ifdef FETCH_DECODE_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    entry_t              r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_push;
    logic                w_pop;
    logic                w_not_empty;
    entry_t              w_head;
    entry_t              w_wr_entry;

    // Status is derived only from the registered count so that in_ready and
    // out_valid never depend combinationally on the inputs.
    assign w_not_empty = (r_count != '0);
    assign in_ready    = (r_count != CNT_W'(DEPTH));
    assign out_valid   = w_not_empty;
    assign count       = r_count;

    // Flush suppresses both sides of the handshake for this edge.
    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = w_not_empty & out_ready & ~flush;

    assign w_wr_entry.pc   = in_pc;
    assign w_wr_entry.inst = in_inst;

    assign w_head   = r_mem[r_rd_ptr];
    assign out_inst = w_not_empty ? w_head.inst : NOP_INST;
    assign out_pc   = w_not_empty ? w_head.pc   : '0;

    // Storage needs no reset: an entry is only observed after it was written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

`ifdef FETCH_DECODE_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Performance counter survives flushes; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_not_empty && !out_ready && !flush && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
